// File: rtl/pc_fetch_if.sv
// Fetch-unit bundle: instruction-memory handshake, decode handshake,
// next-PC loop and error/status reporting.
interface pc_fetch_if;
   logic [31:0] next_pc;
   logic        instr_ready;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        instr_valid;
   logic [31:0] instr;
   logic        fetch_err;
   logic [1:0]  err_cause;
   logic [31:0] err_pc;
   logic [31:0] retired;

   modport master (
      input  next_pc, instr_ready, imem_ack, imem_rdata,
      output pc, imem_req, imem_addr, instr_valid, instr,
             fetch_err, err_cause, err_pc, retired
   );

   modport slave (
      output next_pc, instr_ready, imem_ack, imem_rdata,
      input  pc, imem_req, imem_addr, instr_valid, instr,
             fetch_err, err_cause, err_pc, retired
   );
endinterface

// File: rtl/pc_fetch.sv
// Program-counter owner: fetches from a handshaked imem, hands words to decode,
// loads next_pc on accept, and parks in a sticky error state on misalign/timeout.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          TIMEOUT  = 16,
   parameter int          TO_W     = 5
) (
   input logic          clk,
   input logic          rst_n,
   pc_fetch_if.master   bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_ERR} state_e;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_MISALGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic [1:0]        err_cause_q, err_cause_d;
   logic [31:0]       err_pc_q, err_pc_d;
   logic [31:0]       retired_q, retired_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         instr_valid_q <= 1'b0;
         err_cause_q   <= CAUSE_NONE;
         err_pc_q      <= 32'h0;
         retired_q     <= 32'h0;
         to_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         err_cause_q   <= err_cause_d;
         err_pc_q      <= err_pc_d;
         retired_q     <= retired_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      err_cause_d   = err_cause_q;
      err_pc_d      = err_pc_q;
      retired_d     = retired_q;
      to_cnt_d      = to_cnt_q;

      unique case (state_q)
         S_IDLE: state_d = S_REQ;

         S_REQ: begin
            // Ack takes priority over the timeout firing in the same cycle.
            if (bus.imem_ack) begin
               instr_d       = bus.imem_rdata;
               instr_valid_d = 1'b1;
               to_cnt_d      = '0;
               state_d       = S_VALID;
            end else if (to_cnt_q == TO_LAST) begin
               err_cause_d = CAUSE_TIMEOUT;
               err_pc_d    = pc_q;
               to_cnt_d    = '0;
               state_d     = S_ERR;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         S_VALID: begin
            if (bus.instr_ready) begin
               retired_d     = retired_q + 32'd1;
               pc_d          = bus.next_pc;
               instr_valid_d = 1'b0;
               if (bus.next_pc[1:0] == 2'b00) begin
                  state_d = S_REQ;
               end else begin
                  err_cause_d = CAUSE_MISALGN;
                  err_pc_d    = bus.next_pc;
                  state_d     = S_ERR;
               end
            end
         end

         S_ERR: instr_valid_d = 1'b0;

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.pc          = pc_q;
   assign bus.imem_addr   = pc_q;
   assign bus.imem_req    = (state_q == S_REQ);
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr       = instr_q;
   assign bus.fetch_err   = (state_q == S_ERR);
   assign bus.err_cause   = err_cause_q;
   assign bus.err_pc      = err_pc_q;
   assign bus.retired     = retired_q;

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Owns the program counter and fetches instructions from a handshaked instruction memory.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Drives `pc` into the next-PC calculator and loads that block's `next_pc` result when decode accepts the current instruction.
- Detects misaligned next-PC values and instruction-memory timeouts, and stops with a sticky error.

Parameters:
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- TIMEOUT, 16: maximum REQ cycles without `imem_ack` before an error is declared; must be ≥ 2.
- TO_W, 5: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- next_pc  input  32  next PC from the next-PC calculator, computed from `pc` and the decoded `instr`.
- instr_ready  input  1  decode accepts the instruction this cycle.
- imem_ack  input  1  instruction memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid when `imem_ack` = 1.
- pc  output  32  current PC, fed to the next-PC calculator.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; always equals `pc`.
- instr_valid  output  1  `instr` holds a valid instruction.
- instr  output  32  latched instruction word.
- fetch_err  output  1  sticky error flag.
- err_cause  output  2  00 none, 01 misaligned next_pc, 10 fetch timeout.
- err_pc  output  32  offending address.
- retired  output  32  count of instructions accepted by decode.

Behaviour:
- Reset (rst_n = 0 at a clock edge, regardless of state), next-cycle values:
  - state = IDLE.
  - pc = RESET_PC.
  - imem_req = 0, instr_valid = 0, instr = 0.
  - fetch_err = 0, err_cause = 00, err_pc = 0.
  - retired = 0, timeout counter = 0.
  - Reset mid-request abandons the request; a late `imem_ack` after reset is ignored unless the FSM is in REQ.
- States:
  - IDLE: outputs quiet; go to REQ on the next cycle unconditionally.
  - REQ:
    - imem_req = 1, imem_addr = pc, timeout counter increments each cycle.
    - On imem_ack = 1: instr <= imem_rdata, instr_valid <= 1, counter <= 0, go to VALID.
    - Otherwise, when the counter reaches TIMEOUT-1: go to ERR with err_cause <= 10, err_pc <= pc.
    - If imem_ack arrives in the same cycle the counter hits TIMEOUT-1, the ack wins (VALID, no error).
  - VALID:
    - imem_req = 0; instr_valid = 1; instr is held stable while instr_ready = 0.
    - On instr_ready = 1:
      - retired <= retired + 1 (wraps modulo 2^32).
      - pc <= next_pc.
      - If next_pc[1:0] == 00: instr_valid <= 0, go to REQ.
      - If next_pc[1:0] != 00: go to ERR with err_cause <= 01, err_pc <= next_pc, instr_valid <= 0. pc still loads next_pc.
  - ERR:
    - fetch_err = 1; imem_req = 0; instr_valid = 0.
    - err_cause and err_pc are held; pc is frozen.
    - Exits only via reset.
- Timing:
  - Ack in cycle N → instr_valid high in cycle N+1.
  - Best-case throughput: one instruction per 2 cycles (REQ with immediate ack, then VALID with instr_ready = 1).
  - imem_req stays high continuously through REQ until ack; it never toggles within one request.
  - imem_ack is ignored outside REQ.
  - instr_ready is ignored outside VALID.
  - next_pc is sampled only on the accept edge.
- Widths:
  - pc, err_pc and retired are 32-bit.
  - No arithmetic is performed on pc inside this block; PC increment and branch arithmetic belong to the next-PC calculator.

Test Plan:
- Reset, then imem_ack = 1 on the first REQ cycle with imem_rdata = 32'h3C01_1234, instr_ready = 1, next_pc = 32'h0000_3004 → imem_addr = 32'h0000_3000; instr_valid high exactly one cycle after ack; then pc = 32'h0000_3004, REQ re-entered, retired = 1.
- Backpressure: instr_ready = 0 for 5 VALID cycles → instr held at 32'h3C01_1234; imem_req = 0; retired and pc unchanged; accept on cycle 6 advances both.
- Branch: next_pc = 32'h0000_3010 at accept → next imem_addr = 32'h0000_3010; misaligned next_pc = 32'h0000_3012 → fetch_err = 1, err_cause = 01, err_pc = 32'h0000_3012, imem_req stays 0.
- Timeout with TIMEOUT = 16 and no ack → fetch_err = 1 after the 16th REQ cycle, err_cause = 10, err_pc = request pc; ack in exactly the 16th cycle → no error, instr_valid next cycle.
- rst_n low during REQ, and separately during ERR → next cycle all outputs at reset values and pc = 32'h0000_3000; a late ack arriving in IDLE is ignored.
- Retired-counter wrap: force retired to 32'hFFFF_FFFF, then accept one instruction → retired = 0.
